// File: rtl/sha_padder.sv
// sha_padder: SHA-2 message padder that packs a byte stream into 512-bit blocks for a hash engine.
// Define SHA_PADDER_ABORT_EN to add an abort input that drops the message in progress.
package sha;
    typedef enum logic [1:0] {MODE_SHA256 = 2'd0, MODE_SHA224 = 2'd1} mode_t;
    typedef logic [511:0] msg_t;
    typedef logic [255:0] hash_t;
endpackage

interface sha_engine_if;
    logic       clk;
    logic       rstn;
    sha::mode_t mode;
    logic       new_msg;
    logic       valid;
    sha::msg_t  msg;
    sha::hash_t hash;
    logic       ready;
    modport master(output clk, rstn, mode, new_msg, valid, msg, input hash, ready);
    modport slave(input clk, rstn, mode, new_msg, valid, msg, output hash, ready);
endinterface

module sha_padder (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    input  logic [2:0]  s_bytes,
    input  sha::mode_t  s_mode,
`ifdef SHA_PADDER_ABORT_EN
    input  logic        abort,
`endif
    sha_engine_if.master eng,
    output logic        h_valid,
    output sha::hash_t  h_data,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, FILL, SEND, WAIT, PAD, SEND_PAD, WAIT_PAD, DONE} state_t;
    state_t      r_state, w_next;
    sha::msg_t   r_msg, w_fill;
    sha::mode_t  r_mode;
    logic [60:0] r_cnt;
    logic [3:0]  r_idx;
    logic [5:0]  r_ppos;
    logic        r_first, r_pad_blk, r_pad2;
    logic [31:0] w_lword;
    logic [63:0] w_len;
    logic [2:0]  w_nb;
    logic        w_xfer, w_valid, w_full_last, w_fits, w_abort;

`ifdef SHA_PADDER_ABORT_EN
    assign w_abort = abort && r_state != IDLE;
`else
    assign w_abort = 1'b0;
`endif

    assign eng.clk     = clk;
    assign eng.rstn    = ~rst;
    assign eng.mode    = r_mode;
    assign eng.msg     = r_msg;
    assign eng.valid   = w_valid;
    assign eng.new_msg = r_first && w_valid;
    assign w_valid     = r_state == SEND || r_state == SEND_PAD;
    assign s_ready     = ~rst && (r_state == IDLE || r_state == FILL);
    assign busy        = r_state != IDLE;
    assign h_valid     = r_state == DONE;
    assign w_xfer      = s_valid && s_ready;
    assign w_nb        = s_bytes > 3'd4 ? 3'd4 : s_bytes;
    assign w_full_last = r_idx == 4'd15 && w_nb == 3'd4;
    assign w_len       = {r_cnt, 3'b000};
    // the 64-bit length fits behind the 0x80 marker only if it sits at byte 55 or earlier
    assign w_fits      = r_ppos <= 6'd55;

    always_comb begin
        w_lword = '0;
        for (int k = 0; k < 4; k++)
            w_lword[31-8*k -: 8] = 3'(k) < w_nb ? s_data[31-8*k -: 8] : (3'(k) == w_nb ? 8'h80 : 8'h00);
    end

    always_comb begin
        w_fill = r_msg;
        for (int j = 0; j < 16; j++)
            if (4'(j) == r_idx)
                w_fill[511-32*j -: 32] = s_last ? w_lword : s_data;
            else if (s_last && 4'(j) > r_idx)
                w_fill[511-32*j -: 32] = (4'(j) == r_idx + 4'd1 && w_nb == 3'd4) ? 32'h8000_0000 : 32'h0;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, FILL: if (w_xfer) w_next = s_last ? (w_full_last ? SEND : PAD) : (r_idx == 4'd15 ? SEND : FILL);
            SEND:       if (eng.ready) w_next = WAIT;
            WAIT:       if (eng.ready) w_next = r_pad_blk ? PAD : FILL;
            PAD:        w_next = SEND_PAD;
            SEND_PAD:   if (eng.ready) w_next = WAIT_PAD;
            WAIT_PAD:   if (eng.ready) w_next = r_pad2 ? SEND_PAD : DONE;
            default:    w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_msg     <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_ppos    <= '0;
            r_first   <= 1'b0;
            r_pad_blk <= 1'b0;
            r_pad2    <= 1'b0;
            r_mode    <= sha::MODE_SHA256;
            h_data    <= '0;
        end else if (w_abort) begin
            r_msg     <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_first   <= 1'b0;
            r_pad_blk <= 1'b0;
            r_pad2    <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_msg     <= w_fill;
                r_idx     <= r_idx + 4'd1;
                r_cnt     <= r_cnt + (s_last ? 61'(w_nb) : 61'd4);
                r_ppos    <= {r_idx, 2'b00} + 6'(w_nb);
                r_pad_blk <= s_last && w_full_last;
                if (r_state == IDLE) begin
                    r_mode  <= s_mode;
                    r_first <= 1'b1;
                end
            end
            if (w_valid && eng.ready) r_first <= 1'b0;
            if (r_state == WAIT && eng.ready && r_pad_blk) begin
                r_msg     <= {8'h80, 504'b0};
                r_ppos    <= '0;
                r_pad_blk <= 1'b0;
            end
            if (r_state == PAD) begin
                if (w_fits) r_msg[63:0] <= w_len;
                else        r_pad2 <= 1'b1;
            end
            // the final hash is captured on the last ready so h_valid follows it by one cycle
            if (r_state == WAIT_PAD && eng.ready) begin
                if (r_pad2) begin
                    r_msg  <= {448'b0, w_len};
                    r_pad2 <= 1'b0;
                end else
                    h_data <= eng.hash;
            end
            if (r_state == DONE) begin
                r_cnt <= '0;
                r_idx <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sha_padder.sv
// tb_sha_padder: directed bench for sha_padder with a SHA-256 engine model behind the engine port.
module tb_sha_padder;
    localparam sha::hash_t IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam sha::hash_t ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam sha::hash_t EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic [31:0] s_data = '0;
    logic [2:0]  s_bytes = '0;
    sha::mode_t  s_mode = sha::MODE_SHA256;
    logic        s_ready, h_valid, busy;
    sha::hash_t  h_data;
`ifdef SHA_PADDER_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic        hold = 1'b0;
    logic        e_rdy;
    int          e_cnt;
    sha::hash_t  e_h;
    sha::msg_t   blks [$];
    logic        newf [$];
    sha::mode_t  modes [$];
    int          hv_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    sha_engine_if eng();

    sha_padder dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .s_bytes(s_bytes), .s_mode(s_mode),
`ifdef SHA_PADDER_ABORT_EN
        .abort(abort),
`endif
        .eng(eng), .h_valid(h_valid), .h_data(h_data), .busy(busy));

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic sha::hash_t sha_blk(input sha::hash_t h, input sha::msg_t m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // engine model: accepts a block on valid&&ready, then stays busy for a few cycles
    assign eng.ready = e_rdy && !hold;
    assign eng.hash  = e_h;

    always @(posedge clk or posedge rst)
        if (rst) begin
            e_h   <= '0;
            e_rdy <= 1'b1;
            e_cnt <= 0;
        end else if (eng.valid && eng.ready) begin
            blks.push_back(eng.msg);
            newf.push_back(eng.new_msg);
            modes.push_back(eng.mode);
            e_h   <= sha_blk(eng.new_msg ? IV : e_h, eng.msg);
            e_rdy <= 1'b0;
            e_cnt <= 3;
        end else if (!e_rdy) begin
            e_cnt <= e_cnt - 1;
            if (e_cnt == 1) e_rdy <= 1'b1;
        end

    always @(posedge clk) if (h_valid) hv_cnt <= hv_cnt + 1;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mbyte(input int i, input logic [7:0] seed);
        return seed + 8'(i);
    endfunction

    task automatic clear_log();
        blks.delete();
        newf.delete();
        modes.delete();
    endtask

    // drives n message bytes; stop_w > 0 sends only that many words and never raises s_last
    task automatic send(input int n, input logic [7:0] seed, input sha::mode_t md, input int stop_w);
        int nw;
        nw = stop_w > 0 ? stop_w : (n == 0 ? 1 : (n + 3) / 4);
        for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            int g;
            g = 0;
            for (int k = 0; k < 4; k++) d[31-8*k -: 8] = (4*w + k < n) ? mbyte(4*w + k, seed) : 8'hEE;
            s_valid = 1'b1;
            s_data  = d;
            s_mode  = w == 0 ? md : (md == sha::MODE_SHA256 ? sha::MODE_SHA224 : sha::MODE_SHA256);
            s_last  = stop_w == 0 && w == nw - 1;
            s_bytes = s_last ? 3'(n - 4*w) : 3'd0;
            while (!s_ready && g < 500) begin
                @(negedge clk);
                g++;
            end
            if (!s_ready) check("s_ready_timeout", 512'(s_ready), 512'(1));
            @(posedge clk);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_h(input string tag);
        int g;
        g = 0;
        while (!h_valid && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check($sformatf("%s_hvalid", tag), 512'(h_valid), 512'(1));
        @(negedge clk);
        check($sformatf("%s_hpulse", tag), 512'(h_valid), 512'(0));
    endtask

    task automatic expect_msg(input string tag, input int n, input logic [7:0] seed, input sha::mode_t md,
                              input logic kh, input sha::hash_t hx);
        logic [7:0]  p [192];
        sha::msg_t   x;
        sha::hash_t  h;
        logic [63:0] len;
        int          nb;
        nb  = (n + 72) / 64;
        len = 64'(n) << 3;
        h   = IV;
        for (int i = 0; i < 192; i++) p[i] = i < n ? mbyte(i, seed) : (i == n ? 8'h80 : 8'h00);
        for (int k = 0; k < 8; k++) p[nb*64 - 8 + k] = len[63-8*k -: 8];
        wait_h(tag);
        check($sformatf("%s_nblk", tag), 512'(blks.size()), 512'(nb));
        for (int b = 0; b < nb && b < int'(blks.size()); b++) begin
            for (int i = 0; i < 64; i++) x[511-8*i -: 8] = p[64*b + i];
            check($sformatf("%s_blk%0d", tag, b), blks[b], x);
            check($sformatf("%s_new%0d", tag, b), 512'(newf[b]), 512'(b == 0));
            check($sformatf("%s_mode%0d", tag, b), 512'(modes[b]), 512'(md));
            h = sha_blk(h, x);
        end
        check($sformatf("%s_hash", tag), 512'(h_data), 512'(h));
        if (kh) check($sformatf("%s_known", tag), 512'(h_data), 512'(hx));
    endtask

    task automatic run(input string tag, input int n, input logic [7:0] seed, input sha::mode_t md,
                       input logic kh, input sha::hash_t hx);
        clear_log();
        send(n, seed, md, 0);
        expect_msg(tag, n, seed, md, kh, hx);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        sha::msg_t m0;
        int g;
        int hv0;
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_s_ready", 512'(s_ready), 512'(0));
        check("rst_valid", 512'(eng.valid), 512'(0));
        check("rst_new", 512'(eng.new_msg), 512'(0));
        check("rst_msg", eng.msg, 512'(0));
        check("rst_mode", 512'(eng.mode), 512'(0));
        check("rst_rstn", 512'(eng.rstn), 512'(0));
        check("rst_hvalid", 512'(h_valid), 512'(0));
        check("rst_hdata", 512'(h_data), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_s_ready", 512'(s_ready), 512'(1));
        check("idle_rstn", 512'(eng.rstn), 512'(1));

        run("abc", 3, 8'h61, sha::MODE_SHA256, 1'b1, ABC);
        check("abc_blk_exact", blks[0], {32'h61626380, 416'b0, 64'h18});
        run("empty", 0, 8'h00, sha::MODE_SHA256, 1'b1, EMPTY);
        check("empty_blk_exact", blks[0], {8'h80, 504'b0});
        run("b55", 55, 8'h10, sha::MODE_SHA224, 1'b0, '0);
        run("b56", 56, 8'h20, sha::MODE_SHA256, 1'b0, '0);
        run("b63", 63, 8'h30, sha::MODE_SHA256, 1'b0, '0);
        run("b64", 64, 8'h40, sha::MODE_SHA256, 1'b0, '0);
        check("b64_pad_head", 512'(blks[1][511:504]), 512'(8'h80));
        check("b64_pad_len", 512'(blks[1][63:0]), 512'(64'h200));
        run("b100", 100, 8'h03, sha::MODE_SHA224, 1'b0, '0);

        clear_log();
        hold = 1'b1;
        send(8, 8'h90, sha::MODE_SHA224, 0);
        g = 0;
        while (!eng.valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        m0 = eng.msg;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("stall_valid%0d", c), 512'(eng.valid), 512'(1));
            check($sformatf("stall_msg%0d", c), eng.msg, m0);
            check($sformatf("stall_s_ready%0d", c), 512'(s_ready), 512'(0));
            check($sformatf("stall_mode%0d", c), 512'(eng.mode), 512'(sha::MODE_SHA224));
            @(negedge clk);
        end
        hold = 1'b0;
        expect_msg("stall", 8, 8'h90, sha::MODE_SHA224, 1'b0, '0);

        clear_log();
        send(80, 8'h55, sha::MODE_SHA256, 16);
        g = 0;
        while (blks.size() == 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("wait_busy", 512'(busy), 512'(1));
        check("wait_valid", 512'(eng.valid), 512'(0));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 512'(busy), 512'(0));
        check("midrst_msg", eng.msg, 512'(0));
        check("midrst_hdata", 512'(h_data), 512'(0));
        rst = 1'b0;
        @(negedge clk);
        run("abc_after_rst", 3, 8'h61, sha::MODE_SHA256, 1'b1, ABC);

`ifdef SHA_PADDER_ABORT_EN
        clear_log();
        send(40, 8'h77, sha::MODE_SHA256, 3);
        check("abort_busy_before", 512'(busy), 512'(1));
        hv0 = hv_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 512'(busy), 512'(0));
        check("abort_msg", eng.msg, 512'(0));
        repeat (20) @(negedge clk);
        check("abort_no_hvalid", 512'(hv_cnt), 512'(hv0));
        check("abort_no_blk", 512'(blks.size()), 512'(0));
        run("abc_after_abort", 3, 8'h61, sha::MODE_SHA256, 1'b1, ABC);
`else
        hv0 = hv_cnt;
        repeat (5) @(negedge clk);
        check("idle_no_hvalid", 512'(hv_cnt), 512'(hv0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
